// File: rtl/port_allocator.sv
// Output-port allocator: round-robin lock of one input until its tail flit, with credit-based flow control.
// Optional lock watchdog is enabled by defining PORT_ALLOC_WATCHDOG_EN.
module port_allocator #(
    parameter int MAX_CREDITS = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    input  logic [4:0] tail,
    input  logic       credit_inc,
    output logic [4:0] grant,
    output logic [4:0] fire,
    output logic [3:0] credits,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t     state_reg, state_next;
    logic [4:0] grant_reg, grant_next;
    logic [2:0] rr_ptr_reg, rr_ptr_next;
    logic [3:0] credits_reg, credits_next;

    logic       has_credit;
    logic       any_fire;
    logic [4:0] pick_oh;
    logic [2:0] owner_idx;
    logic       tail_release;
    logic       release_lock;
    logic [3:0] scan_idx;

    assign has_credit = (credits_reg != 4'd0);

    // A flit moves only from the current owner, and only while a downstream slot is free.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_fire
            assign fire[gi] = (state_reg == LOCKED) & grant_reg[gi] & req[gi] & has_credit;
        end
    endgenerate

    assign any_fire     = |fire;
    assign tail_release = any_fire & |(tail & grant_reg);

    // Round-robin pick: first requester at or above rr_ptr, wrapping modulo 5.
    always_comb begin
        pick_oh  = 5'd0;
        scan_idx = 4'd0;
        for (int k = 0; k < 5; k++) begin
            scan_idx = {1'b0, rr_ptr_reg} + 4'(k);
            if (scan_idx >= 4'd5) begin
                scan_idx = scan_idx - 4'd5;
            end
            if (pick_oh == 5'd0 && req[scan_idx[2:0]]) begin
                pick_oh[scan_idx[2:0]] = 1'b1;
            end
        end
    end

    always_comb begin
        owner_idx = 3'd0;
        for (int k = 0; k < 5; k++) begin
            if (grant_reg[k]) begin
                owner_idx = 3'(k);
            end
        end
    end

    // Simultaneous fire and return cancel; saturate at both ends.
    always_comb begin
        credits_next = credits_reg;
        if (any_fire && !credit_inc) begin
            credits_next = credits_reg - 4'd1;
        end else if (!any_fire && credit_inc && credits_reg < 4'(MAX_CREDITS)) begin
            credits_next = credits_reg + 4'd1;
        end
    end

`ifdef PORT_ALLOC_WATCHDOG_EN
    logic [7:0] wd_cnt_reg, wd_cnt_next;
    logic       timeout_reg, timeout_next;
    logic       wd_expire;

    // Counts consecutive stalled LOCKED cycles; idles at zero so entering LOCKED starts fresh.
    always_comb begin
        wd_cnt_next  = 8'd0;
        wd_expire    = 1'b0;
        timeout_next = 1'b0;
        if (state_reg == LOCKED && !any_fire) begin
            if (wd_cnt_reg == 8'(TIMEOUT - 1)) begin
                wd_expire    = 1'b1;
                timeout_next = 1'b1;
            end else begin
                wd_cnt_next = wd_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_reg  <= 8'd0;
            timeout_reg <= 1'b0;
        end else begin
            wd_cnt_reg  <= wd_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign release_lock = tail_release | wd_expire;
    assign timeout      = timeout_reg;
`else
    assign release_lock = tail_release;
    assign timeout      = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (req != 5'd0 && has_credit) begin
                    state_next = LOCKED;
                    grant_next = pick_oh;
                end
            end
            LOCKED: begin
                if (release_lock) begin
                    state_next  = IDLE;
                    grant_next  = 5'd0;
                    rr_ptr_next = (owner_idx == 3'd4) ? 3'd0 : owner_idx + 3'd1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            grant_reg   <= 5'd0;
            rr_ptr_reg  <= 3'd0;
            credits_reg <= 4'(MAX_CREDITS);
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            rr_ptr_reg  <= rr_ptr_next;
            credits_reg <= credits_next;
        end
    end

    assign grant   = grant_reg;
    assign credits = credits_reg;

endmodule

// File: doc/port_allocator.md
PORT_ALLOCATOR -- requirements
Module: port_allocator

Interface
REQ-001 SHALL have parameter MAX_CREDITS, default 4, downstream buffer depth in flits (1..15).
REQ-002 SHALL have parameter TIMEOUT, default 16, watchdog idle limit in cycles (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  5  per-input flit request; bit order [0]=L, [1]=N, [2]=E, [3]=W, [4]=S.
REQ-006 SHALL have port tail  input  5  per-input tail-flit flag (flit_id 3'b100); meaningful only with the matching req bit.
REQ-007 SHALL have port credit_inc  input  1  one-cycle pulse, downstream freed one buffer slot.
REQ-008 SHALL have port grant  output  5  registered one-hot owner of the output port; 0 when unowned.
REQ-009 SHALL have port fire  output  5  combinational one-hot, flit transferred this cycle.
REQ-010 SHALL have port credits  output  4  registered available downstream credits.
REQ-011 SHALL have port timeout  output  1  registered one-cycle pulse, watchdog released the lock.

Function
REQ-012 SHALL implement two states: IDLE (grant=0) and LOCKED (grant one-hot).
REQ-013 IDLE: if req!=0 and credits!=0, the next state SHALL be LOCKED.
- grant SHALL be the first set req bit searching from rr_ptr upward, mod 5.
- Otherwise the block SHALL stay in IDLE.
REQ-014 IDLE with credits==0 SHALL NOT grant, whatever req holds.
REQ-015 fire[i] SHALL equal LOCKED & grant[i] & req[i] & (credits!=0); fire SHALL be 0 in IDLE.
REQ-016 Each fire SHALL decrement credits by 1 at the next edge.
REQ-017 Each credit_inc SHALL increment credits by 1 at the next edge.
REQ-018 Fire and credit_inc in the same cycle SHALL leave credits unchanged.
REQ-019 credit_inc at credits==MAX_CREDITS (without a fire) SHALL be ignored; credits SHALL never exceed MAX_CREDITS or go below 0.
REQ-020 Fire with tail[owner]=1 SHALL release the lock: the next state is IDLE, grant=0, and rr_ptr=(owner+1) mod 5.
REQ-021 The lock SHALL persist across cycles with req[owner]=0 or credits==0; other req bits SHALL be ignored while LOCKED.
REQ-022 Grant latency SHALL be exactly 1 cycle from the qualifying IDLE cycle. The minimum gap between packets SHALL be 1 IDLE cycle after a tail.
REQ-023 A single-flit packet (head with tail=1) SHALL hold the lock for exactly one fire.

Reset
REQ-024 When rst=1 at a posedge, the block SHALL load: state=IDLE, grant=0, rr_ptr=0 (L), credits=MAX_CREDITS, timeout=0, watchdog count=0.
REQ-025 Reset mid-packet SHALL drop the lock immediately. Any credit_inc in that cycle SHALL be discarded.
REQ-026 fire SHALL be 0 during the reset cycle's following state (IDLE).

Configuration
REQ-027 Macro PORT_ALLOC_WATCHDOG_EN defined: a counter SHALL count consecutive LOCKED cycles with no fire.
- The counter SHALL clear on any fire or when entering LOCKED.
- On reaching TIMEOUT, the lock SHALL release as for a tail, rr_ptr SHALL advance past the owner, and timeout SHALL pulse for 1 cycle.
REQ-028 Macro PORT_ALLOC_WATCHDOG_EN undefined: there SHALL be no counter, timeout SHALL be tied 0, and the lock SHALL be held until the tail.

Verification
REQ-029 After reset, req=5'b10010 -> one cycle later grant=5'b00010 (N), credits=4.
REQ-030 N sends a 3-flit packet (tail on third), no credit_inc.
- Response: fire[1] for 3 cycles, credits 4->1, grant=0 after the tail.
- Response: rr_ptr=2, and with req=5'b10011 held, the next grant=5'b10000 (S).
REQ-031 Credits exhausted: owner E sends a 6-flit packet, credit_inc=0.
- Response: fire stops after 4 flits, credits=0, grant held.
- One credit_inc -> credits=1, and the fifth flit fires the following cycle.
REQ-032 Simultaneous fire and credit_inc at credits=2 -> credits stays 2. credit_inc alone at credits=4 -> stays 4.
REQ-033 With PORT_ALLOC_WATCHDOG_EN and TIMEOUT=16: owner W drops req after one non-tail flit.
- Response: timeout pulses exactly 16 cycles after the last fire, then grant=0 and rr_ptr=4.
- Without the macro: grant stays 5'b01000 indefinitely and timeout stays 0.
REQ-034 Assert rst while L is locked mid-packet with credits=1 -> next cycle grant=0, credits=4, fire=0.
